mem_req_arbiter: RTL and testbench

- Sits between the instruction cache, the load/store buffer (LSB) and the byte-serial memory controller.
- Owns the controller's single request port. Latches one requester's transaction and holds it stable downstream until completion.
- Routes the completion pulse and data back to the originating requester.
- Enforces LSB-over-fetch priority with a starvation guard for fetches, and discards results of in-flight loads/fetches on pipeline flush.

---
 rtl/mem_req_arbiter_pkg.sv | 22 ++
 rtl/arb_starve_counter.sv | 32 +++
 rtl/mem_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared opcode codes plus the arbiter's local FSM and owner encodings.
package mem_req_arbiter_pkg;

    localparam int unsigned OPC_W = 6;

    localparam logic [OPC_W-1:0] OPC_LB  = 6'h01;
    localparam logic [OPC_W-1:0] OPC_LH  = 6'h02;
    localparam logic [OPC_W-1:0] OPC_LW  = 6'h03;
    localparam logic [OPC_W-1:0] OPC_LBU = 6'h04;
    localparam logic [OPC_W-1:0] OPC_LHU = 6'h05;
    localparam logic [OPC_W-1:0] OPC_SB  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_SH  = 6'h09;
    localparam logic [OPC_W-1:0] OPC_SW  = 6'h0A;

    typedef enum logic [1:0] {StIdle, StGrant, StWait, StResp} arb_state_e;
    typedef enum logic [1:0] {OwnNone, OwnIf, OwnLs} arb_owner_e;

    function automatic logic is_store(input logic [OPC_W-1:0] t);
        return (t == OPC_SB) || (t == OPC_SH) || (t == OPC_SW);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts LSB grants taken while a fetch waits; flags when the fetch must go next.
module arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic force_fetch_o
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rdy_i) begin
            if (clr_i) begin
                cnt_q <= '0;
            end else if (inc_i && (cnt_q != Limit)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign force_fetch_o = (cnt_q == Limit);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates icache fetches and LSB requests onto the single memory-controller request port.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned OPT_W        = OPC_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_i,
    input  logic              flush_i,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              ls_valid_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [OPT_W-1:0]  ls_type_i,
    output logic              ls_done_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              mc_if_valid_o,
    output logic              mc_ls_valid_o,
    output logic [ADDR_W-1:0] mc_addr_o,
    output logic [DATA_W-1:0] mc_wdata_o,
    output logic [OPT_W-1:0]  mc_type_o,
    input  logic              mc_if_done_i,
    input  logic              mc_ls_done_i,
    input  logic [DATA_W-1:0] mc_rdata_i
);

    arb_state_e        state_q;
    arb_owner_e        owner_q;
    logic              kill_q;
    logic              mc_if_valid_q, mc_ls_valid_q;
    logic [ADDR_W-1:0] mc_addr_q;
    logic [DATA_W-1:0] mc_wdata_q;
    logic [OPT_W-1:0]  mc_type_q;
    logic              if_done_q, ls_done_q;
    logic [DATA_W-1:0] if_data_q, ls_rdata_q;

    logic force_fetch, pick_ls, grant, grant_if, grant_ls;
    logic in_flight, owner_done, kill_set, kill_now;

    always_comb begin
        pick_ls    = ls_valid_i && !(if_valid_i && force_fetch);
        grant      = (state_q == StIdle) && !flush_i && (if_valid_i || ls_valid_i);
        grant_if   = grant && !pick_ls;
        grant_ls   = grant && pick_ls;
        in_flight  = (state_q == StGrant) || (state_q == StWait);
        owner_done = ((owner_q == OwnIf) && mc_if_done_i) || ((owner_q == OwnLs) && mc_ls_done_i);
        // Fetches and loads become stale on flush; stores must still retire.
        kill_set   = flush_i && in_flight &&
                     ((owner_q == OwnIf) ||
                      ((owner_q == OwnLs) && !is_store(OPC_W'(mc_type_q))));
        kill_now   = kill_q || kill_set;
    end

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk           (clk),
        .rst           (rst),
        .rdy_i         (rdy_i),
        .clr_i         (flush_i || grant_if),
        .inc_i         (grant_ls && if_valid_i),
        .force_fetch_o (force_fetch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_q       <= OwnNone;
            kill_q        <= 1'b0;
            mc_if_valid_q <= 1'b0;
            mc_ls_valid_q <= 1'b0;
            mc_addr_q     <= '0;
            mc_wdata_q    <= '0;
            mc_type_q     <= '0;
            if_done_q     <= 1'b0;
            ls_done_q     <= 1'b0;
            if_data_q     <= '0;
            ls_rdata_q    <= '0;
        end else if (rdy_i) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q       <= StGrant;
                        owner_q       <= pick_ls ? OwnLs : OwnIf;
                        kill_q        <= 1'b0;
                        mc_if_valid_q <= !pick_ls;
                        mc_ls_valid_q <= pick_ls;
                        mc_addr_q     <= pick_ls ? ls_addr_i : if_addr_i;
                        mc_wdata_q    <= pick_ls ? ls_wdata_i : '0;
                        mc_type_q     <= pick_ls ? ls_type_i : '0;
                    end
                end
                StGrant, StWait: begin
                    if (kill_set) begin
                        kill_q <= 1'b1;
                    end
                    if (owner_done) begin
                        state_q       <= StResp;
                        mc_if_valid_q <= 1'b0;
                        mc_ls_valid_q <= 1'b0;
                        if (!kill_now && (owner_q == OwnIf)) begin
                            if_done_q <= 1'b1;
                            if_data_q <= mc_rdata_i;
                        end
                        if (!kill_now && (owner_q == OwnLs)) begin
                            ls_done_q  <= 1'b1;
                            ls_rdata_q <= mc_rdata_i;
                        end
                    end else begin
                        state_q <= StWait;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    owner_q <= OwnNone;
                    kill_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A completion must only come back for the side currently in flight.
    a_if_done_owned: assert property (@(posedge clk) disable iff (rst)
        (rdy_i && mc_if_done_i) |-> (in_flight && (owner_q == OwnIf)));
    a_ls_done_owned: assert property (@(posedge clk) disable iff (rst)
        (rdy_i && mc_ls_done_i) |-> (in_flight && (owner_q == OwnLs)));

    assign mc_if_valid_o = mc_if_valid_q;
    assign mc_ls_valid_o = mc_ls_valid_q;
    assign mc_addr_o     = mc_addr_q;
    assign mc_wdata_o    = mc_wdata_q;
    assign mc_type_o     = mc_type_q;
    assign if_done_o     = if_done_q;
    assign if_data_o     = if_data_q;
    assign ls_done_o     = ls_done_q;
    assign ls_rdata_o    = ls_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scoreboard bench: expected issues/completions are queued and popped as they appear.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    typedef struct {
        int          cyc;
        bit          is_ls;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  typ;
    } iss_t;

    typedef struct {
        int          cyc;
        bit          is_ls;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        if_valid, ls_valid;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [5:0]  ls_type;
    logic        if_done, ls_done;
    logic [31:0] if_data, ls_rdata;
    logic        mc_if_valid, mc_ls_valid;
    logic [31:0] mc_addr, mc_wdata;
    logic [5:0]  mc_type;
    logic        mc_if_done, mc_ls_done;
    logic [31:0] mc_rdata;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   prev_v = 1'b0;

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .rdy_i         (rdy),
        .flush_i       (flush),
        .if_valid_i    (if_valid),
        .if_addr_i     (if_addr),
        .if_done_o     (if_done),
        .if_data_o     (if_data),
        .ls_valid_i    (ls_valid),
        .ls_addr_i     (ls_addr),
        .ls_wdata_i    (ls_wdata),
        .ls_type_i     (ls_type),
        .ls_done_o     (ls_done),
        .ls_rdata_o    (ls_rdata),
        .mc_if_valid_o (mc_if_valid),
        .mc_ls_valid_o (mc_ls_valid),
        .mc_addr_o     (mc_addr),
        .mc_wdata_o    (mc_wdata),
        .mc_type_o     (mc_type),
        .mc_if_done_i  (mc_if_done),
        .mc_ls_done_i  (mc_ls_done),
        .mc_rdata_i    (mc_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_iss(input int c, input bit l, input logic [31:0] a,
                            input logic [31:0] w, input logic [5:0] t);
        iss_t e;
        e.cyc = c; e.is_ls = l; e.addr = a; e.wdata = w; e.typ = t;
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input int c, input bit l, input logic [31:0] d);
        rsp_t e;
        e.cyc = c; e.is_ls = l; e.data = d;
        rsp_q.push_back(e);
    endtask

    // Advance one cycle, then pop and check any issue or completion the DUT shows.
    task automatic tick();
        iss_t ie;
        rsp_t re;
        @(posedge clk);
        #1;
        cyc++;
        if ((mc_if_valid || mc_ls_valid) && !prev_v) begin
            chk("issue_expected", 64'(iss_q.size() != 0), 64'(1));
            if (iss_q.size() != 0) begin
                ie = iss_q.pop_front();
                chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
                chk("issue_ls_valid", 64'(mc_ls_valid), 64'(ie.is_ls));
                chk("issue_if_valid", 64'(mc_if_valid), 64'(!ie.is_ls));
                chk("issue_addr", 64'(mc_addr), 64'(ie.addr));
                chk("issue_wdata", 64'(mc_wdata), 64'(ie.wdata));
                chk("issue_type", 64'(mc_type), 64'(ie.typ));
            end
        end
        prev_v = mc_if_valid || mc_ls_valid;
        if (if_done || ls_done) begin
            chk("resp_expected", 64'(rsp_q.size() != 0), 64'(1));
            if (rsp_q.size() != 0) begin
                re = rsp_q.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(re.cyc));
                chk("resp_ls_done", 64'(ls_done), 64'(re.is_ls));
                chk("resp_if_done", 64'(if_done), 64'(!re.is_ls));
                chk("resp_data", 64'(re.is_ls ? ls_rdata : if_data), 64'(re.data));
            end
        end
    endtask

    // Controller model: complete the outstanding request after w wait cycles.
    task automatic serve(input bit l, input int w, input logic [31:0] d, input bit pulse);
        repeat (w) tick();
        if (l) mc_ls_done = 1'b1;
        else   mc_if_done = 1'b1;
        mc_rdata = d;
        if (pulse) push_rsp(cyc + 1, l, d);
        tick();
        mc_ls_done = 1'b0;
        mc_if_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        if_valid = 1'b0; if_addr = '0;
        ls_valid = 1'b0; ls_addr = '0; ls_wdata = '0; ls_type = '0;
        mc_if_done = 1'b0; mc_ls_done = 1'b0; mc_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mc_if_valid", 64'(mc_if_valid), 64'(0));
        chk("rst_mc_ls_valid", 64'(mc_ls_valid), 64'(0));
        chk("rst_mc_addr", 64'(mc_addr), 64'(0));
        chk("rst_if_done", 64'(if_done), 64'(0));
        chk("rst_ls_done", 64'(ls_done), 64'(0));
        chk("rst_if_data", 64'(if_data), 64'(0));

        // Single fetch, completion 6 cycles after issue.
        if_valid = 1'b1; if_addr = 32'h1000;
        push_iss(cyc + 1, 1'b0, 32'h1000, 32'h0, 6'h0);
        tick();
        serve(1'b0, 5, 32'h0000_0013, 1'b1);
        if_valid = 1'b0;
        tick();
        chk("fetch_valid_drop", 64'(mc_if_valid), 64'(0));
        tick();

        // Simultaneous requests: store wins, fetch follows two cycles after completion.
        if_valid = 1'b1; if_addr = 32'h2000;
        ls_valid = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF; ls_type = OPC_SW;
        push_iss(cyc + 1, 1'b1, 32'h20, 32'hDEAD_BEEF, OPC_SW);
        tick();
        ls_addr = 32'hFFFF_FFF0; ls_wdata = 32'h0;
        tick();
        chk("latched_addr", 64'(mc_addr), 64'(32'h20));
        chk("latched_wdata", 64'(mc_wdata), 64'(32'hDEAD_BEEF));
        serve(1'b1, 2, 32'h0, 1'b1);
        ls_valid = 1'b0;
        push_iss(cyc + 2, 1'b0, 32'h2000, 32'h0, 6'h0);
        tick();
        chk("gap_cycle_idle", 64'(mc_if_valid || mc_ls_valid), 64'(0));
        tick();
        serve(1'b0, 3, 32'h1234, 1'b1);
        if_valid = 1'b0;
        tick();
        tick();

        // Starvation guard: four loads, then the waiting fetch is forced through.
        if_valid = 1'b1; if_addr = 32'h3000;
        ls_valid = 1'b1; ls_type = OPC_LW; ls_addr = 32'h100; ls_wdata = '0;
        push_iss(cyc + 1, 1'b1, 32'h100, 32'h0, OPC_LW);
        tick();
        for (int k = 0; k < 4; k++) begin
            serve(1'b1, 1, 32'h100 + 32'(k), 1'b1);
            if (k < 3) begin
                ls_addr = 32'h104 + 32'(4 * k);
                push_iss(cyc + 2, 1'b1, ls_addr, 32'h0, OPC_LW);
            end else begin
                push_iss(cyc + 2, 1'b0, 32'h3000, 32'h0, 6'h0);
            end
            tick();
            tick();
        end
        serve(1'b0, 1, 32'h0000_F00D, 1'b1);
        ls_addr = 32'h200;
        push_iss(cyc + 2, 1'b1, 32'h200, 32'h0, OPC_LW);
        tick();
        tick();
        serve(1'b1, 1, 32'h2, 1'b1);
        if_valid = 1'b0; ls_valid = 1'b0;
        tick();
        tick();

        // Flushed load: completes downstream but produces no pulse.
        ls_valid = 1'b1; ls_type = OPC_LW; ls_addr = 32'h100; ls_wdata = '0;
        push_iss(cyc + 1, 1'b1, 32'h100, 32'h0, OPC_LW);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        serve(1'b1, 2, 32'h55, 1'b0);
        chk("killed_no_ls_done", 64'(ls_done), 64'(0));
        chk("killed_valid_drop", 64'(mc_ls_valid), 64'(0));
        ls_valid = 1'b0;
        if_valid = 1'b1; if_addr = 32'h4000;
        push_iss(cyc + 2, 1'b0, 32'h4000, 32'h0, 6'h0);
        tick();
        tick();
        serve(1'b0, 2, 32'h77, 1'b1);
        if_valid = 1'b0;
        tick();
        tick();

        // Flushed store still retires.
        ls_valid = 1'b1; ls_type = OPC_SB; ls_addr = 32'h3_0000; ls_wdata = 32'hAB;
        push_iss(cyc + 1, 1'b1, 32'h3_0000, 32'hAB, OPC_SB);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        serve(1'b1, 2, 32'h0, 1'b1);
        ls_valid = 1'b0;
        tick();
        tick();

        // Flush blocks a grant; then rdy low freezes a fetch in flight.
        if_valid = 1'b1; if_addr = 32'h5000; flush = 1'b1;
        tick();
        chk("flush_no_grant", 64'(mc_if_valid), 64'(0));
        flush = 1'b0;
        push_iss(cyc + 1, 1'b0, 32'h5000, 32'h0, 6'h0);
        tick();
        tick();
        rdy = 1'b0;
        mc_if_done = 1'b1; mc_rdata = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            mc_if_done = 1'b0;
            chk("frozen_valid", 64'(mc_if_valid), 64'(1));
            chk("frozen_addr", 64'(mc_addr), 64'(32'h5000));
            chk("frozen_no_done", 64'(if_done), 64'(0));
        end
        rdy = 1'b1;
        serve(1'b0, 1, 32'h99, 1'b1);
        if_valid = 1'b0;
        tick();
        tick();

        chk("issues_left", 64'(iss_q.size()), 64'(0));
        chk("resps_left", 64'(rsp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
